phase_chk_axis_sink: RTL and testbench



---
 rtl/phase_chk_pkg.sv | 24 ++
 rtl/phase_chk_axis_sink_if.sv | 23 ++
 rtl/phase_delta_cmp.sv | 23 ++
 rtl/phase_chk_axis_sink.sv | 173 +++++++++++++++++
 tb/tb_phase_chk_axis_sink.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/phase_chk_pkg.sv
// Phase checker shared types and constants.
// Holds FSM state encoding, LFSR constants and saturation limit.
package phase_chk_pkg;

  typedef enum logic [2:0] {
    WAIT    = 3'd0,
    FIRST   = 3'd1,
    TRAIN   = 3'd2,
    ACQUIRE = 3'd3,
    LOCKED  = 3'd4
  } state_t;

  localparam logic [7:0]  LFSR_SEED = 8'hA5;
  // Taps 8,6,5,4 of a left-shifting Fibonacci LFSR.
  localparam logic [7:0]  LFSR_TAPS = 8'hB8;
  localparam logic [15:0] ERR_SAT   = 16'hFFFF;

  function automatic logic [7:0] lfsr_next(
    input logic [7:0] s
  );
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/phase_chk_axis_sink_if.sv
// AXI-Stream phase word link between generator and checker.
// Master drives TVALID/TDATA, slave drives TREADY.
interface phase_chk_axis_sink_if #(
  parameter int W = 16
);

  logic         TVALID;
  logic [W-1:0] TDATA;
  logic         TREADY;

  modport master (
    output TVALID,
    output TDATA,
    input  TREADY
  );

  modport slave (
    input  TVALID,
    input  TDATA,
    output TREADY
  );

endinterface

// File: rtl/phase_delta_cmp.sv
// Modulo phase delta and signed tolerance compare.
// Purely combinational; wrap through zero is not a mismatch.
module phase_delta_cmp #(
  parameter int W         = 16,
  parameter int TOLERANCE = 0
) (
  input  logic [W-1:0] data,
  input  logic [W-1:0] prev,
  input  logic [W-1:0] step,
  output logic [W-1:0] delta,
  output logic         match
);

  logic signed [W-1:0] diff;
  int                  diff_i;

  assign delta  = data - prev;
  assign diff   = delta - step;
  assign diff_i = int'(diff);
  assign match  = (diff_i >= -TOLERANCE) &&
                  (diff_i <= TOLERANCE);

endmodule

// File: rtl/phase_chk_axis_sink.sv
// Phase-step lock checker on an AXI-Stream sink.
// Optional PHASE_CHK_BACKPRESSURE_EN adds LFSR-driven stalls.
module phase_chk_axis_sink
  import phase_chk_pkg::*;
#(
  parameter int C_S_AXIS_TDATA_WIDTH = 16,
  parameter int C_S_START_COUNT      = 32,
  parameter int LOCK_COUNT           = 8,
  parameter int MISS_LIMIT           = 4,
  parameter int TOLERANCE            = 0
) (
  input  logic        S_AXIS_ACLK,
  input  logic        S_AXIS_ARESET,
  phase_chk_axis_sink_if.slave S_AXIS,
  input  logic        clr_stats,
  output logic        locked,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0] step_est,
  output logic [15:0] err_count,
  output logic [31:0] sample_count,
  output logic [2:0]  chk_state
);

  localparam int W   = C_S_AXIS_TDATA_WIDTH;
  localparam int WCW = $clog2(C_S_START_COUNT + 1);
  localparam int MCW = $clog2(LOCK_COUNT + 1);
  localparam int SCW = $clog2(MISS_LIMIT + 1);

  state_t         state_q, state_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic [W-1:0]   prev_q, prev_d;
  logic [W-1:0]   step_q, step_d;
  logic [MCW-1:0] match_q, match_d, match_inc;
  logic [SCW-1:0] miss_q, miss_d, miss_inc;
  logic [15:0]    err_q, err_d;
  logic [31:0]    smp_q, smp_d;

  logic         active, ready, beat, match;
  logic [W-1:0] delta;

  assign active = state_q inside
    {FIRST, TRAIN, ACQUIRE, LOCKED};

`ifdef PHASE_CHK_BACKPRESSURE_EN
  logic [7:0] lfsr_q;

  // Pseudo-random stall source, frozen while waiting.
  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
    if (S_AXIS_ARESET)
      lfsr_q <= LFSR_SEED;
    else if (state_q != WAIT)
      lfsr_q <= lfsr_next(lfsr_q);
  end

  assign ready = active && !lfsr_q[0];
`else
  assign ready = active;
`endif

  assign S_AXIS.TREADY = ready;
  assign beat = S_AXIS.TVALID && ready;

  phase_delta_cmp #(
    .W(W),
    .TOLERANCE(TOLERANCE)
  ) u_cmp (
    .data(S_AXIS.TDATA),
    .prev(prev_q),
    .step(step_q),
    .delta(delta),
    .match(match)
  );

  assign match_inc = match_q + 1'b1;
  assign miss_inc  = miss_q + 1'b1;

  // Next-state, step tracking and statistics.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    prev_d  = prev_q;
    step_d  = step_q;
    match_d = match_q;
    miss_d  = miss_q;
    err_d   = err_q;
    smp_d   = smp_q;
    if (beat) begin
      prev_d = S_AXIS.TDATA;
      smp_d  = smp_q + 32'd1;
    end
    unique case (state_q)
      WAIT: begin
        wait_d = wait_q + 1'b1;
        if (wait_q == WCW'(C_S_START_COUNT - 1)) begin
          wait_d  = '0;
          state_d = FIRST;
        end
      end
      FIRST: begin
        if (beat) state_d = TRAIN;
      end
      TRAIN: begin
        if (beat) begin
          step_d  = delta;
          match_d = '0;
          state_d = ACQUIRE;
        end
      end
      ACQUIRE: begin
        if (beat && match) begin
          match_d = match_inc;
          if (match_inc == MCW'(LOCK_COUNT)) begin
            state_d = LOCKED;
            miss_d  = '0;
          end
        end else if (beat) begin
          step_d  = delta;
          match_d = '0;
        end
      end
      LOCKED: begin
        if (beat && match) begin
          miss_d = '0;
        end else if (beat) begin
          if (err_q != ERR_SAT) err_d = err_q + 16'd1;
          miss_d = miss_inc;
          if (miss_inc == SCW'(MISS_LIMIT)) begin
            state_d = ACQUIRE;
            step_d  = delta;
            match_d = '0;
          end
        end
      end
      default: begin
        state_d = WAIT;
        wait_d  = '0;
      end
    endcase
    if (clr_stats) begin
      err_d = '0;
      smp_d = '0;
    end
  end

  // Checker state and statistics registers.
  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
    if (S_AXIS_ARESET) begin
      state_q <= WAIT;
      wait_q  <= '0;
      prev_q  <= '0;
      step_q  <= '0;
      match_q <= '0;
      miss_q  <= '0;
      err_q   <= '0;
      smp_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      prev_q  <= prev_d;
      step_q  <= step_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
      smp_q   <= smp_d;
    end
  end

  assign locked       = (state_q == LOCKED);
  assign step_est     = step_q;
  assign err_count    = err_q;
  assign sample_count = smp_q;
  assign chk_state    = state_q;

endmodule

// File: tb/tb_phase_chk_axis_sink.sv
// Directed bench for phase_chk_axis_sink.
// Build with PHASE_CHK_BACKPRESSURE_EN to add the stall run.
module tb_phase_chk_axis_sink;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        locked;
  logic [15:0] step_est;
  logic [15:0] err_count;
  logic [31:0] sample_count;
  logic [2:0]  chk_state;

  int errors = 0;
  int checks = 0;
  logic [15:0] p;
  int cnt;

  phase_chk_axis_sink_if #(.W(16)) s_axis ();

  phase_chk_axis_sink dut (
    .S_AXIS_ACLK(clk),
    .S_AXIS_ARESET(rst),
    .S_AXIS(s_axis),
    .clr_stats(clr),
    .locked(locked),
    .step_est(step_est),
    .err_count(err_count),
    .sample_count(sample_count),
    .chk_state(chk_state)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Offer one word; clr is applied only on the accepting edge.
  task automatic send(
    input logic [15:0] d,
    input logic        c
  );
    logic rdy;
    int   n;
    rdy = 1'b0;
    n   = 0;
    s_axis.TVALID = 1'b1;
    s_axis.TDATA  = d;
    do begin
      @(negedge clk);
      rdy = s_axis.TREADY;
      clr = c && rdy;
      @(posedge clk);
      #1;
      clr = 1'b0;
      n++;
    end while (!rdy && n < 64);
    s_axis.TVALID = 1'b0;
    checks++;
    assert (rdy) else begin
      errors++;
      $error("FAIL send_timeout: got no accept expected accept");
    end
  endtask

  task automatic wait_len(input string tag);
    cnt = 0;
    while (cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
      if (chk_state != 3'd0) break;
    end
    chk(tag, cnt, 32);
  endtask

  initial begin
    s_axis.TVALID = 1'b1;
    s_axis.TDATA  = 16'h0000;
    #12;
    chk("rst_tready", {31'd0, s_axis.TREADY}, 0);
    chk("rst_locked", {31'd0, locked}, 0);
    chk("rst_step", {16'd0, step_est}, 0);
    chk("rst_err", {16'd0, err_count}, 0);
    chk("rst_smp", sample_count, 0);
    chk("rst_state", {29'd0, chk_state}, 0);

    @(negedge clk);
    rst = 1'b0;
    wait_len("wait_len");
    chk("wait_no_beats", sample_count, 0);
    chk("first_state", {29'd0, chk_state}, 1);
`ifndef PHASE_CHK_BACKPRESSURE_EN
    chk("first_tready", {31'd0, s_axis.TREADY}, 1);
`endif
    s_axis.TVALID = 1'b0;

    p = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      send(p, 1'b0);
      if (i == 8) chk("lock_9th", {31'd0, locked}, 0);
      if (i < 9) p = p + 16'h3000;
    end
    chk("lock_10th", {31'd0, locked}, 1);
    chk("lock_step", {16'd0, step_est}, 32'h3000);
    chk("lock_smp", sample_count, 10);
    chk("lock_state", {29'd0, chk_state}, 4);

    for (int k = 0; k < 3; k++) begin
      p = p + 16'h1234;
      send(p, 1'b0);
    end
    chk("bad3_locked", {31'd0, locked}, 1);
    chk("bad3_err", {16'd0, err_count}, 3);
    p = p + 16'h3000;
    send(p, 1'b0);
    chk("good_locked", {31'd0, locked}, 1);
    chk("good_err", {16'd0, err_count}, 3);

    for (int k = 0; k < 4; k++) begin
      p = p + 16'h1234;
      send(p, 1'b0);
      if (k == 2) chk("bad4_mid", {31'd0, locked}, 1);
    end
    chk("bad4_locked", {31'd0, locked}, 0);
    chk("bad4_step", {16'd0, step_est}, 32'h1234);
    chk("bad4_err", {16'd0, err_count}, 7);
    chk("bad4_state", {29'd0, chk_state}, 3);
    chk("bad4_smp", sample_count, 18);

    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("clr_err", {16'd0, err_count}, 0);
    chk("clr_smp", sample_count, 0);
    chk("clr_state", {29'd0, chk_state}, 3);
    chk("clr_step", {16'd0, step_est}, 32'h1234);

    for (int k = 0; k < 40; k++) begin
      p = p + 16'hF000;
      send(p, 1'b0);
    end
    chk("wrap_locked", {31'd0, locked}, 1);
    chk("wrap_err", {16'd0, err_count}, 0);
    chk("wrap_step", {16'd0, step_est}, 32'hF000);
    chk("wrap_smp", sample_count, 40);

    p = p + 16'h1234;
    send(p, 1'b1);
    chk("clrbeat_err", {16'd0, err_count}, 0);
    chk("clrbeat_smp", sample_count, 0);
    chk("clrbeat_locked", {31'd0, locked}, 1);
    p = p + 16'h1234;
    send(p, 1'b0);
    chk("post_err", {16'd0, err_count}, 1);
    chk("post_smp", sample_count, 1);
    chk("post_locked", {31'd0, locked}, 1);

    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_tready", {31'd0, s_axis.TREADY}, 0);
    chk("mid_locked", {31'd0, locked}, 0);
    chk("mid_step", {16'd0, step_est}, 0);
    chk("mid_err", {16'd0, err_count}, 0);
    chk("mid_smp", sample_count, 0);
    chk("mid_state", {29'd0, chk_state}, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_len("rewait_len");

`ifdef PHASE_CHK_BACKPRESSURE_EN
    p = 16'h0000;
    for (int i = 0; i < 1000; i++) begin
      send(p, 1'b0);
      p = p + 16'h3000;
    end
    chk("bp_err", {16'd0, err_count}, 0);
    chk("bp_smp", sample_count, 1000);
    chk("bp_locked", {31'd0, locked}, 1);
    chk("bp_step", {16'd0, step_est}, 32'h3000);
`endif

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
